// File: rtl/bus_trace_probe_if.sv
// Bus and readout signals of the trace probe. The probe is the slave side; the
// environment that owns the memory bus and consumes the trace is the master side.
interface bus_trace_probe_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic          cs;
    logic          rw;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;

    // Readout handshake: an entry moves on any edge where rd_valid && rd_ready.
    // While rd_valid=1 and rd_ready=0, rd_rw/rd_addr/rd_data stay constant.
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_rw;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    modport master (
        output cs, rw, address, data_in, data_out, rd_ready,
        input  rd_valid, rd_rw, rd_addr, rd_data
    );

    modport slave (
        input  cs, rw, address, data_in, data_out, rd_ready,
        output rd_valid, rd_rw, rd_addr, rd_data
    );
endinterface

// File: rtl/bus_trace_probe.sv
// Passive memory-bus probe: circular trace with pre-trigger history, post-trigger
// window, saturating read/write counters and oldest-first valid/ready readout.
module bus_trace_probe #(
    parameter int AW    = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    bus_trace_probe_if.slave         bus,
    input  logic                     arm,
    input  logic [1:0]               trig_mode,
    input  logic [AW-1:0]            trig_addr,
    input  logic [$clog2(DEPTH)-1:0] post_count,
    output logic [1:0]               state,
    output logic                     triggered,
    output logic                     overflow,
    output logic [CW-1:0]            wr_cnt,
    output logic [CW-1:0]            rd_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 1 + AW + DW;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

    state_t        state_q;
    logic [PW-1:0] wptr_q;
    logic [PW:0]   fill_q;
    logic [PW-1:0] remain_q;
    logic [PW-1:0] post_q;
    logic [1:0]    mode_q;
    logic [AW-1:0] taddr_q;
    logic          triggered_q;
    logic          overflow_q;
    logic [CW-1:0] wr_cnt_q;
    logic [CW-1:0] rd_cnt_q;
    logic [EW-1:0] mem_q [DEPTH];

    logic          capturing;
    logic          hit;
    logic          rd_valid_w;
    logic          accept;
    logic [EW-1:0] entry;
    logic [PW-1:0] rptr;

    always_comb begin
        capturing  = !arm && bus.cs && (state_q == S_ARMED || state_q == S_POST);
        entry      = {bus.rw, bus.address, bus.rw ? bus.data_out : bus.data_in};
        hit        = 1'b0;
        unique case (mode_q)
            2'd0: hit = 1'b1;
            2'd1: hit = (bus.address == taddr_q);
            2'd2: hit = (bus.address == taddr_q) && !bus.rw;
            2'd3: hit = (bus.address == taddr_q) && bus.rw;
        endcase
        // wptr is frozen in DONE, so wptr - fill always names the oldest unread entry.
        rptr       = wptr_q - fill_q[PW-1:0];
        rd_valid_w = (state_q == S_DONE) && (fill_q != '0);
        accept     = rd_valid_w && bus.rd_ready;
    end

    always_ff @(posedge clk) begin
        if (capturing) mem_q[wptr_q] <= entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            fill_q      <= '0;
            remain_q    <= '0;
            post_q      <= '0;
            mode_q      <= '0;
            taddr_q     <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else if (arm) begin
            state_q     <= S_ARMED;
            wptr_q      <= '0;
            fill_q      <= '0;
            remain_q    <= '0;
            post_q      <= post_count;
            mode_q      <= trig_mode;
            taddr_q     <= trig_addr;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            case (state_q)
                S_ARMED, S_POST: begin
                    if (bus.cs) begin
                        wptr_q <= wptr_q + PW'(1);
                        if (fill_q == (PW+1)'(DEPTH)) overflow_q <= 1'b1;
                        else                           fill_q     <= fill_q + (PW+1)'(1);
                        if (bus.rw) begin
                            if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CW'(1);
                        end else begin
                            if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + CW'(1);
                        end
                        if (state_q == S_ARMED) begin
                            if (hit) begin
                                triggered_q <= 1'b1;
                                remain_q    <= post_q;
                                state_q     <= (post_q == '0) ? S_DONE : S_POST;
                            end
                        end else begin
                            remain_q <= remain_q - PW'(1);
                            if (remain_q == PW'(1)) state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (accept) begin
                        fill_q <= fill_q - (PW+1)'(1);
                        if (fill_q == (PW+1)'(1)) state_q <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state         = state_q;
    assign triggered     = triggered_q;
    assign overflow      = overflow_q;
    assign wr_cnt        = wr_cnt_q;
    assign rd_cnt        = rd_cnt_q;
    assign bus.rd_valid  = rd_valid_w;
    assign {bus.rd_rw, bus.rd_addr, bus.rd_data} = mem_q[rptr];
endmodule

// File: tb/tb_bus_trace_probe.sv
// Directed bench for bus_trace_probe: default instance plus a CW=4 instance that
// shadows the same bus traffic to exercise counter saturation.
module tb_bus_trace_probe;
  logic       clk;
  logic       rst;
  logic       arm;
  logic [1:0] trig_mode;
  logic [3:0] trig_addr;
  logic [3:0] post_count;

  logic [1:0]  state, state4;
  logic        triggered, triggered4;
  logic        overflow, overflow4;
  logic [15:0] wr_cnt, rd_cnt;
  logic [3:0]  wr_cnt4, rd_cnt4;

  int vec_cnt;
  int err_cnt;
  logic [20:0] exp_q[$];

  bus_trace_probe_if #(.AW(4), .DW(16)) bus ();
  bus_trace_probe_if #(.AW(4), .DW(16)) bus4 ();

  assign bus4.cs       = bus.cs;
  assign bus4.rw       = bus.rw;
  assign bus4.address  = bus.address;
  assign bus4.data_in  = bus.data_in;
  assign bus4.data_out = bus.data_out;
  assign bus4.rd_ready = bus.rd_ready;

  bus_trace_probe #(.AW(4), .DW(16), .DEPTH(16), .CW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .arm(arm), .trig_mode(trig_mode),
    .trig_addr(trig_addr), .post_count(post_count), .state(state),
    .triggered(triggered), .overflow(overflow), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  bus_trace_probe #(.AW(4), .DW(16), .DEPTH(16), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .arm(arm), .trig_mode(trig_mode),
    .trig_addr(trig_addr), .post_count(post_count), .state(state4),
    .triggered(triggered4), .overflow(overflow4), .wr_cnt(wr_cnt4), .rd_cnt(rd_cnt4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic bus_cycle(input logic rw, input logic [3:0] a, input logic [15:0] d);
    bus.cs = 1'b1;
    bus.rw = rw;
    bus.address = a;
    bus.data_in  = rw ? ~d : d;
    bus.data_out = rw ? d : ~d;
    @(posedge clk); #1;
    bus.cs = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [3:0] a, input logic [3:0] p);
    arm = 1'b1;
    trig_mode = m;
    trig_addr = a;
    post_count = p;
    @(posedge clk); #1;
    arm = 1'b0;
    // scramble trigger settings to show they were latched at arm
    trig_mode = ~m;
    trig_addr = ~a;
    post_count = ~p;
  endtask

  // scoreboard: drains readout, compares against exp_q, checks stall stability
  task automatic drain_scoreboard(input bit random_ready, input string name);
    int budget;
    logic prev_stall;
    logic [20:0] prev_entry;
    logic [20:0] cur;
    budget = 400;
    prev_stall = 1'b0;
    prev_entry = '0;
    while (exp_q.size() > 0 && budget > 0) begin
      budget--;
      bus.rd_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cur = {bus.rd_rw, bus.rd_addr, bus.rd_data};
      vec_cnt++;
      if (bus.rd_valid !== 1'b1) begin
        err_cnt++;
        $display("FAIL %s rd_valid: got %b expected 1 (%0d entries left)", name, bus.rd_valid, exp_q.size());
      end else begin
        if (prev_stall) begin
          vec_cnt++;
          if (cur !== prev_entry) begin
            err_cnt++;
            $display("FAIL %s stall_stable: got %h expected %h", name, cur, prev_entry);
          end
        end
        if (bus.rd_ready) begin
          vec_cnt++;
          if (cur !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL %s entry: got %h expected %h", name, cur, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        prev_stall = !bus.rd_ready;
        prev_entry = cur;
      end
      @(posedge clk); #1;
    end
    bus.rd_ready = 1'b0;
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL %s drain_timeout: got %0d entries left expected 0", name, exp_q.size());
      exp_q.delete();
    end
    vec_cnt++;
    if (state !== 2'd0 || bus.rd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s end_idle: got state=%0d rd_valid=%b expected state=0 rd_valid=0", name, state, bus.rd_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    vec_cnt++;
    if (state !== 2'd0 || triggered !== 1'b0 || overflow !== 1'b0 || bus.rd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_flags: got state=%0d trig=%b ovf=%b rv=%b expected all 0", state, triggered, overflow, bus.rd_valid);
    end
    vec_cnt++;
    if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0) begin
      err_cnt++;
      $display("FAIL reset_counters: got wr=%0d rd=%0d expected 0 0", wr_cnt, rd_cnt);
    end
  endtask

  task automatic test_immediate();
    do_arm(2'd0, 4'd0, 4'd3);
    vec_cnt++;
    if (state !== 2'd1) begin
      err_cnt++;
      $display("FAIL imm_armed: got state=%0d expected 1", state);
    end
    for (int i = 1; i <= 4; i++) begin
      bus_cycle(1'b0, 4'(i), 16'(i * 16'h0011));
      exp_q.push_back({1'b0, 4'(i), 16'(i * 16'h0011)});
      vec_cnt++;
      if (state !== ((i == 4) ? 2'd3 : 2'd2)) begin
        err_cnt++;
        $display("FAIL imm_state_%0d: got %0d expected %0d", i, state, (i == 4) ? 3 : 2);
      end
    end
    vec_cnt++;
    if (wr_cnt !== 16'd4 || rd_cnt !== 16'd0 || triggered !== 1'b1 || overflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL imm_status: got wr=%0d rd=%0d trig=%b ovf=%b expected 4 0 1 0", wr_cnt, rd_cnt, triggered, overflow);
    end
    // a bus cycle in DONE must not be recorded or counted
    bus_cycle(1'b0, 4'd9, 16'h9999);
    vec_cnt++;
    if (wr_cnt !== 16'd4) begin
      err_cnt++;
      $display("FAIL imm_done_hold: got wr=%0d expected 4", wr_cnt);
    end
    drain_scoreboard(1'b0, "imm");
  endtask

  task automatic test_wrap();
    do_arm(2'd2, 4'hA, 4'd2);
    for (int k = 0; k < 20; k++) begin
      bus_cycle(1'b1, 4'd3, 16'(k));
      if (k >= 7) exp_q.push_back({1'b1, 4'd3, 16'(k)});
    end
    vec_cnt++;
    if (state !== 2'd1 || overflow !== 1'b1) begin
      err_cnt++;
      $display("FAIL wrap_pre: got state=%0d ovf=%b expected 1 1", state, overflow);
    end
    bus_cycle(1'b0, 4'hA, 16'hBEEF);
    exp_q.push_back({1'b0, 4'hA, 16'hBEEF});
    bus_cycle(1'b1, 4'd3, 16'h0100);
    exp_q.push_back({1'b1, 4'd3, 16'h0100});
    bus_cycle(1'b1, 4'd3, 16'h0101);
    exp_q.push_back({1'b1, 4'd3, 16'h0101});
    vec_cnt++;
    if (state !== 2'd3 || rd_cnt !== 16'd22 || wr_cnt !== 16'd1) begin
      err_cnt++;
      $display("FAIL wrap_done: got state=%0d rd=%0d wr=%0d expected 3 22 1", state, rd_cnt, wr_cnt);
    end
    vec_cnt++;
    if (rd_cnt4 !== 4'd15) begin
      err_cnt++;
      $display("FAIL wrap_rd_sat: got %0d expected 15", rd_cnt4);
    end
    drain_scoreboard(1'b0, "wrap");
  endtask

  task automatic test_read_trigger();
    do_arm(2'd3, 4'd5, 4'd0);
    bus_cycle(1'b0, 4'd5, 16'h5555);
    exp_q.push_back({1'b0, 4'd5, 16'h5555});
    vec_cnt++;
    if (state !== 2'd1 || triggered !== 1'b0) begin
      err_cnt++;
      $display("FAIL rdtrig_write_ignored: got state=%0d trig=%b expected 1 0", state, triggered);
    end
    bus_cycle(1'b1, 4'd5, 16'h1234);
    exp_q.push_back({1'b1, 4'd5, 16'h1234});
    vec_cnt++;
    if (state !== 2'd3 || triggered !== 1'b1) begin
      err_cnt++;
      $display("FAIL rdtrig_fire: got state=%0d trig=%b expected 3 1", state, triggered);
    end
    drain_scoreboard(1'b0, "rdtrig");
  endtask

  task automatic test_backpressure();
    do_arm(2'd1, 4'd6, 4'd5);
    bus_cycle(1'b1, 4'd2, 16'hA001); exp_q.push_back({1'b1, 4'd2, 16'hA001});
    bus_cycle(1'b0, 4'd6, 16'hA002); exp_q.push_back({1'b0, 4'd6, 16'hA002});
    for (int i = 0; i < 5; i++) begin
      bus_cycle(1'(i & 1), 4'(i + 8), 16'(16'hB000 + i));
      exp_q.push_back({1'(i & 1), 4'(i + 8), 16'(16'hB000 + i)});
    end
    vec_cnt++;
    if (state !== 2'd3) begin
      err_cnt++;
      $display("FAIL bp_done: got state=%0d expected 3", state);
    end
    drain_scoreboard(1'b1, "bp");
  endtask

  task automatic test_rearm_and_reset();
    do_arm(2'd0, 4'd0, 4'd10);
    for (int i = 0; i < 3; i++) bus_cycle(1'b0, 4'd1, 16'(i));
    vec_cnt++;
    if (state !== 2'd2 || wr_cnt !== 16'd3) begin
      err_cnt++;
      $display("FAIL rearm_post: got state=%0d wr=%0d expected 2 3", state, wr_cnt);
    end
    do_arm(2'd1, 4'd7, 4'd2);
    vec_cnt++;
    if (state !== 2'd1 || wr_cnt !== 16'd0 || triggered !== 1'b0) begin
      err_cnt++;
      $display("FAIL rearm_clear: got state=%0d wr=%0d trig=%b expected 1 0 0", state, wr_cnt, triggered);
    end
    bus_cycle(1'b0, 4'd1, 16'hC001); exp_q.push_back({1'b0, 4'd1, 16'hC001});
    bus_cycle(1'b0, 4'd7, 16'hC002); exp_q.push_back({1'b0, 4'd7, 16'hC002});
    bus_cycle(1'b1, 4'd1, 16'hC003); exp_q.push_back({1'b1, 4'd1, 16'hC003});
    bus_cycle(1'b0, 4'd2, 16'hC004); exp_q.push_back({1'b0, 4'd2, 16'hC004});
    drain_scoreboard(1'b0, "rearm");

    do_arm(2'd0, 4'd0, 4'd1);
    bus_cycle(1'b0, 4'd3, 16'hD001);
    bus_cycle(1'b0, 4'd4, 16'hD002);
    vec_cnt++;
    if (state !== 2'd3 || bus.rd_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_pre: got state=%0d rv=%b expected 3 1", state, bus.rd_valid);
    end
    #3;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (state !== 2'd0 || bus.rd_valid !== 1'b0 || triggered !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_async: got state=%0d rv=%b trig=%b expected 0 0 0", state, bus.rd_valid, triggered);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    do_arm(2'd2, 4'hF, 4'd0);
    for (int i = 0; i < 20; i++) bus_cycle(1'b0, 4'd1, 16'(i));
    vec_cnt++;
    if (wr_cnt4 !== 4'd15) begin
      err_cnt++;
      $display("FAIL sat_wr4: got %0d expected 15", wr_cnt4);
    end
    vec_cnt++;
    if (wr_cnt !== 16'd20 || state !== 2'd1 || overflow !== 1'b1) begin
      err_cnt++;
      $display("FAIL sat_wr16: got wr=%0d state=%0d ovf=%b expected 20 1 1", wr_cnt, state, overflow);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    arm = 1'b0;
    trig_mode = '0;
    trig_addr = '0;
    post_count = '0;
    bus.cs = 1'b0;
    bus.rw = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    bus.data_out = '0;
    bus.rd_ready = 1'b0;
    test_reset();
    test_immediate();
    test_wrap();
    test_read_trigger();
    test_backpressure();
    test_rearm_and_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
